// File: rtl/cic_interpolator_if.sv
// Sample-stream bundle for the CIC interpolator: low-rate input handshake and high-rate output.
interface cic_interpolator_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OUT_WIDTH  = 22
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_ready;
    logic                         out_valid;
    logic signed [OUT_WIDTH-1:0]  out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: combs run at the input rate, zero-stuffing by R, integrators at en rate.
module cic_interpolator #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 3,
    parameter int unsigned R          = 4,
    parameter int unsigned M          = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_underflow,
    output logic             underflow,
    cic_interpolator_if.slave bus
);
    localparam int unsigned OUT_WIDTH = DATA_WIDTH + N * $clog2(R * M);
    localparam int unsigned PH_W      = $clog2(R);

    logic [PH_W-1:0]      ph_q, ph_d;
    logic [OUT_WIDTH-1:0] dly_q   [N][M];
    logic [OUT_WIDTH-1:0] dly_d   [N][M];
    logic [OUT_WIDTH-1:0] integ_q [N];
    logic [OUT_WIDTH-1:0] integ_d [N];
    logic                 out_valid_q;
    logic                 underflow_q, underflow_d;
    logic                 slot;
    logic [OUT_WIDTH-1:0] comb_x;
    logic [OUT_WIDTH-1:0] u;

    assign slot          = en & ~rst & (ph_q == '0);
    assign bus.in_ready  = slot;
    assign bus.out_data  = integ_q[N-1];
    assign bus.out_valid = out_valid_q;
    assign underflow     = underflow_q;

    always_comb begin
        // A slot without data is processed as a zero sample.
        comb_x = bus.in_valid
               ? {{(OUT_WIDTH - DATA_WIDTH){bus.in_data[DATA_WIDTH-1]}}, bus.in_data}
               : '0;
        for (int k = 0; k < N; k++) begin
            dly_d[k][0] = slot ? comb_x : dly_q[k][0];
            for (int j = 1; j < M; j++) begin
                dly_d[k][j] = slot ? dly_q[k][j-1] : dly_q[k][j];
            end
            comb_x = comb_x - dly_q[k][M-1];
        end
        u = slot ? comb_x : '0;

        integ_d[0] = en ? integ_q[0] + u : integ_q[0];
        for (int k = 1; k < N; k++) begin
            integ_d[k] = en ? integ_q[k] + integ_q[k-1] : integ_q[k];
        end

        ph_d = ph_q;
        if (en) begin
            ph_d = (ph_q == PH_W'(R - 1)) ? '0 : ph_q + 1'b1;
        end

        // Set wins over clear.
        underflow_d = underflow_q;
        if (slot && !bus.in_valid) begin
            underflow_d = 1'b1;
        end else if (clr_underflow) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q        <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
                for (int j = 0; j < M; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
        end else begin
            ph_q        <= ph_d;
            out_valid_q <= en;
            underflow_q <= underflow_d;
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= integ_d[k];
                for (int j = 0; j < M; j++) begin
                    dly_q[k][j] <= dly_d[k][j];
                end
            end
        end
    end
endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench: default-config DUT (N=3,R=4,M=1) plus an N=1 DUT for the zero-order-hold case.
module tb_cic_interpolator;
    logic clk = 1'b0;
    logic rst;
    logic en;
    logic clr_a, clr_b;
    logic uf_a, uf_b;
    int   n_checks = 0;
    int   n_errors = 0;

    // Output after edge t for a DC 100 step from reset (N=3, R=4, M=1).
    int exp_dc [0:11] = '{0, 0, 100, 300, 600, 1000, 1300, 1500, 1600, 1600, 1600, 1600};

    cic_interpolator_if #(.DATA_WIDTH(16), .OUT_WIDTH(22)) bus_a ();
    cic_interpolator_if #(.DATA_WIDTH(16), .OUT_WIDTH(18)) bus_b ();

    cic_interpolator #(.DATA_WIDTH(16), .N(3), .R(4), .M(1)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .clr_underflow (clr_a),
        .underflow     (uf_a),
        .bus           (bus_a.slave)
    );

    cic_interpolator #(.DATA_WIDTH(16), .N(1), .R(4), .M(1)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .clr_underflow (clr_b),
        .underflow     (uf_b),
        .bus           (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_slot();
        int i = 0;
        while (bus_a.in_ready !== 1'b1 && i < 8) begin
            tick();
            i++;
        end
        chk("slot_found", bus_a.in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        clr_a = 1'b0;
        clr_b = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '0;
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = '0;
        tick();
        tick();

        // Reset state, with en=1 held during reset
        chk("rst_ready_a", bus_a.in_ready, 0);
        chk("rst_ready_b", bus_b.in_ready, 0);
        chk("rst_out_a", bus_a.out_data, 0);
        chk("rst_valid_a", bus_a.out_valid, 0);
        chk("rst_uf_a", uf_a, 0);
        chk("rst_out_b", bus_b.out_data, 0);

        // DC 100 on A, impulse on B
        rst = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 16'sd100;
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 16'sd1;
        #1;
        chk("first_ready_a", bus_a.in_ready, 1);
        for (int t = 0; t < 12; t++) begin
            tick();
            if (t == 0) bus_b.in_data = 16'sd0;
            chk("dc_out_a", bus_a.out_data, exp_dc[t]);
            chk("zoh_out_b", bus_b.out_data, (t < 4) ? 1 : 0);
        end
        chk("dc_valid_a", bus_a.out_valid, 1);
        chk("dc_uf_a", uf_a, 0);
        chk("zoh_uf_b", uf_b, 0);

        // Underflow: set, sticky, clear, coincident set+clear
        wait_slot();
        bus_a.in_valid = 1'b0;
        tick();
        bus_a.in_valid = 1'b1;
        chk("uf_set", uf_a, 1);
        tick();
        tick();
        chk("uf_sticky", uf_a, 1);
        chk("uf_not_slot", bus_a.in_ready, 0);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("uf_clr", uf_a, 0);
        wait_slot();
        bus_a.in_valid = 1'b0;
        clr_a = 1'b1;
        tick();
        bus_a.in_valid = 1'b1;
        clr_a = 1'b0;
        chk("uf_coincide", uf_a, 1);

        // Mid-stream reset clears everything, then same transient as power-up
        for (int t = 0; t < 12; t++) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", bus_a.in_ready, 0);
        tick();
        chk("mid_rst_out", bus_a.out_data, 0);
        chk("mid_rst_valid", bus_a.out_valid, 0);
        chk("mid_rst_uf", uf_a, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_after", bus_a.in_ready, 1);
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("rerun_out_a", bus_a.out_data, exp_dc[t]);
        end

        // Alternating en: output per en cycle matches en=1 sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en = 1'b1;
            bus_a.in_valid = 1'b1;
            #1;
            chk("tog_ready_en", bus_a.in_ready, (i % 4 == 0) ? 1 : 0);
            tick();
            chk("tog_out_en", bus_a.out_data, exp_dc[i]);
            chk("tog_valid_en", bus_a.out_valid, 1);
            en = 1'b0;
            bus_a.in_valid = 1'b0;
            #1;
            chk("tog_ready_dis", bus_a.in_ready, 0);
            tick();
            chk("tog_valid_dis", bus_a.out_valid, 0);
            chk("tog_out_hold", bus_a.out_data, exp_dc[i]);
        end
        chk("tog_uf", uf_a, 0);
        en = 1'b1;
        bus_a.in_valid = 1'b1;

        // Most negative input: full-precision result without wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.in_data = 16'sh8000;
        for (int t = 0; t < 12; t++) begin
            tick();
            chk("neg_out_a", bus_a.out_data, (exp_dc[t] / 100) * -32768);
        end
        chk("neg_final", bus_a.out_data, -524288);
        chk("neg_uf", uf_a, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
